// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The writeback stage and a long-latency unit (LLU) share one RF write port.
// Writeback always wins. An LLU result that cannot write immediately waits in a
// one-entry buffer. If writeback keeps the port busy for STARVE_LIMIT cycles,
// the pipeline is stalled until the buffer drains.
//
// Ports:
//   clk, rstN                      clock (rising edge), async active-low reset
//   regWriteW, rdAddrW, resultW    writeback write request
//   lluValid, lluRdAddr, lluData   LLU result offer; lluReady is the accept
//   rfWe, rfAddr, rfData           register-file write port
//   stallPipe                      request to the hazard unit to stall writeback
//   pendValid, pendRd              registered buffer occupancy and destination
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              regWriteW,
  input  logic [ADDR_W-1:0] rdAddrW,
  input  logic [XLEN-1:0]   resultW,
  input  logic              lluValid,
  input  logic [ADDR_W-1:0] lluRdAddr,
  input  logic [XLEN-1:0]   lluData,
  output logic              lluReady,
  output logic              rfWe,
  output logic [ADDR_W-1:0] rfAddr,
  output logic [XLEN-1:0]   rfData,
  output logic              stallPipe,
  output logic              pendValid,
  output logic [ADDR_W-1:0] pendRd
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StHold, StForce} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]   pend_data_q, pend_data_d;

  logic wb_busy, accept, load, drain, waw_kill;

  // x0 writes are architecturally dead, so they never occupy the port.
  assign wb_busy  = regWriteW && (rdAddrW != '0);
  assign accept   = lluValid && !pend_valid_q;
  assign load     = accept && wb_busy && (lluRdAddr != '0);
  assign drain    = pend_valid_q && !wb_busy;
  // A younger writeback to the buffered destination makes the buffered value stale.
  assign waw_kill = pend_valid_q && wb_busy && (rdAddrW == pend_rd_q);

  // Buffer next state.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_data_d  = pend_data_q;
    if (load) begin
      pend_valid_d = 1'b1;
      pend_rd_d    = lluRdAddr;
      pend_data_d  = lluData;
    end else if (drain || waw_kill) begin
      pend_valid_d = 1'b0;
      pend_rd_d    = '0;
    end
  end

  // Starvation FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold, StForce: begin
        if (drain || waw_kill) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // Buffer occupied and not drained: writeback blocked it this cycle.
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntMax) state_d = StForce;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    stall_d = (state_d == StForce);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Write-port mux. Gated by reset so the port is quiet while reset is held.
  always_comb begin
    rfWe   = 1'b0;
    rfAddr = '0;
    rfData = '0;
    if (rstN) begin
      if (wb_busy) begin
        rfWe   = 1'b1;
        rfAddr = rdAddrW;
        rfData = resultW;
      end else if (pend_valid_q) begin
        rfWe   = 1'b1;
        rfAddr = pend_rd_q;
        rfData = pend_data_q;
      end else if (accept && (lluRdAddr != '0)) begin
        rfWe   = 1'b1;
        rfAddr = lluRdAddr;
        rfData = lluData;
      end
    end
  end

  assign lluReady  = !pend_valid_q;
  assign stallPipe = stall_q;
  assign pendValid = pend_valid_q;
  assign pendRd    = pend_rd_q;

endmodule
